spi_serializer: RTL and testbench

SPI_SERIALIZER -- requirements
Module: spi_serializer

---
 rtl/spi_serializer_pkg.sv | 17 +
 rtl/spi_serializer_sclk.sv | 55 +++++
 rtl/spi_serializer.sv | 154 +++++++++++++++
 tb/tb_spi_serializer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_serializer_pkg.sv
// Shared types and helpers for the SPI serializer.
package spi_serializer_pkg;

    // Serializer FSM states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2,
        GAP   = 2'd3
    } state_t;

    // Counter width able to hold n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/spi_serializer_sclk.sv
// Serial clock divider: sclk low for CLK_DIV cycles, then high for CLK_DIV cycles.
// While en_i is low the divider parks with sclk low and the counter reloaded,
// so every new word starts with a full low half-period.
module sclk_gen
    import spi_serializer_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    output logic sclk_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int DW = cnt_width(CLK_DIV);
    localparam logic [DW-1:0] DIV_TOP = DW'(CLK_DIV - 1);

    logic [DW-1:0] div_q, div_d;
    logic          sclk_q, sclk_d;

    // Next divider count, sclk level and the edge strobes for the current cycle.
    always_comb begin
        div_d  = DIV_TOP;
        sclk_d = 1'b0;
        rise_o = 1'b0;
        fall_o = 1'b0;
        if (en_i) begin
            if (div_q == '0) begin
                div_d  = DIV_TOP;
                sclk_d = ~sclk_q;
                rise_o = ~sclk_q;
                fall_o = sclk_q;
            end else begin
                div_d  = div_q - 1'b1;
                sclk_d = sclk_q;
            end
        end
    end

    // Divider state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q  <= DIV_TOP;
            sclk_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            sclk_q <= sclk_d;
        end
    end

    assign sclk_o = sclk_q;

endmodule

// File: rtl/spi_serializer.sv
// SPI mode-0 word serializer with frame-level chip select.
// Handshake: a word moves on any rising clk edge where s_valid && s_ready;
// s_ready never depends combinationally on s_valid, so the source may hold
// s_valid high and change s_data freely while s_ready is low.
module spi_serializer
    import spi_serializer_pkg::*;
#(
    parameter int WORD_WIDTH = 8,
    parameter int CLK_DIV    = 2,
    parameter int CS_GAP     = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [WORD_WIDTH-1:0] s_data,
    input  logic                  s_last,
    input  logic                  lsb_first,
    output logic                  sclk,
    output logic                  sd,
    output logic                  cs_n,
    output logic                  busy
);

    localparam int BW = cnt_width(WORD_WIDTH);
    localparam int GW = cnt_width(CS_GAP);
    localparam logic [BW-1:0] BIT_TOP = BW'(WORD_WIDTH - 1);
    localparam logic [GW-1:0] GAP_TOP = GW'(CS_GAP - 1);

    state_t                  state_q, state_d;
    logic [BW-1:0]           bit_q, bit_d;
    logic [GW-1:0]           gap_q, gap_d;
    logic [WORD_WIDTH-1:0]   shreg_q, shreg_d;
    logic                    lsb_q, lsb_d;
    logic                    last_q, last_d;
    logic                    sd_q, sd_d;
    logic                    cs_n_q, cs_n_d;
    logic                    last_bit_q, last_bit_d;
    logic                    in_reset_q;

    logic sclk_w, rise_w, fall_w;
    logic word_end, ready_w, xfer;

    sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk (
        .clk    (clk),
        .rst    (rst),
        .en_i   (state_q == SHIFT),
        .sclk_o (sclk_w),
        .rise_o (rise_w),
        .fall_o (fall_w)
    );

    // last_bit_q marks that the final bit's rising edge has passed, so the
    // next falling strobe closes the word.
    assign word_end = fall_w && last_bit_q;
    assign ready_w  = !in_reset_q &&
                      ((state_q == IDLE) || (state_q == HOLD) ||
                       ((state_q == SHIFT) && word_end && !last_q));
    assign xfer     = s_valid && ready_w;

    // Next-state logic: load on transfer, otherwise shift, hold or release cs_n.
    always_comb begin
        state_d    = state_q;
        bit_d      = bit_q;
        gap_d      = gap_q;
        shreg_d    = shreg_q;
        lsb_d      = lsb_q;
        last_d     = last_q;
        sd_d       = sd_q;
        cs_n_d     = cs_n_q;
        last_bit_d = last_bit_q;
        if (xfer) begin
            // Only possible in IDLE, HOLD or at the very end of a word.
            state_d    = SHIFT;
            cs_n_d     = 1'b0;
            shreg_d    = s_data;
            lsb_d      = lsb_first;
            last_d     = s_last;
            bit_d      = BIT_TOP;
            last_bit_d = 1'b0;
            sd_d       = lsb_first ? s_data[0] : s_data[WORD_WIDTH-1];
        end else begin
            case (state_q)
                SHIFT: begin
                    if (rise_w && (bit_q == '0)) begin
                        last_bit_d = 1'b1;
                    end
                    if (word_end) begin
                        if (last_q) begin
                            state_d = GAP;
                            cs_n_d  = 1'b1;
                            gap_d   = GAP_TOP;
                        end else begin
                            state_d = HOLD;
                        end
                    end else if (fall_w) begin
                        bit_d = bit_q - 1'b1;
                        if (lsb_q) begin
                            shreg_d = shreg_q >> 1;
                            sd_d    = shreg_q[1];
                        end else begin
                            shreg_d = shreg_q << 1;
                            sd_d    = shreg_q[WORD_WIDTH-2];
                        end
                    end
                end
                GAP: begin
                    if (gap_q == '0) begin
                        state_d = IDLE;
                    end else begin
                        gap_d = gap_q - 1'b1;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    // State and datapath registers; reset aborts any word in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            bit_q      <= '0;
            gap_q      <= '0;
            shreg_q    <= '0;
            lsb_q      <= 1'b0;
            last_q     <= 1'b0;
            sd_q       <= 1'b0;
            cs_n_q     <= 1'b1;
            last_bit_q <= 1'b0;
            in_reset_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            bit_q      <= bit_d;
            gap_q      <= gap_d;
            shreg_q    <= shreg_d;
            lsb_q      <= lsb_d;
            last_q     <= last_d;
            sd_q       <= sd_d;
            cs_n_q     <= cs_n_d;
            last_bit_q <= last_bit_d;
            in_reset_q <= 1'b0;
        end
    end

    assign sclk    = sclk_w;
    assign sd      = sd_q;
    assign cs_n    = cs_n_q;
    assign busy    = (state_q != IDLE);
    assign s_ready = ready_w;

endmodule

// File: tb/tb_spi_serializer.sv
// Directed bench for spi_serializer: a default-parameter instance (8/2/2)
// and a 9-bit, CLK_DIV=1 instance sharing clock and reset.
module tb_spi_serializer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Instance A: WORD_WIDTH=8, CLK_DIV=2, CS_GAP=2
    logic       a_valid = 1'b0, a_last = 1'b0, a_lsb = 1'b0;
    logic [7:0] a_data = 8'h00;
    logic       a_ready, a_sclk, a_sd, a_cs_n, a_busy;

    // Instance B: WORD_WIDTH=9, CLK_DIV=1, CS_GAP=2
    logic       b_valid = 1'b0, b_last = 1'b0, b_lsb = 1'b0;
    logic [8:0] b_data = 9'h000;
    logic       b_ready, b_sclk, b_sd, b_cs_n, b_busy;

    spi_serializer #(.WORD_WIDTH(8), .CLK_DIV(2), .CS_GAP(2)) dut_a (
        .clk(clk), .rst(rst), .s_valid(a_valid), .s_ready(a_ready),
        .s_data(a_data), .s_last(a_last), .lsb_first(a_lsb),
        .sclk(a_sclk), .sd(a_sd), .cs_n(a_cs_n), .busy(a_busy)
    );

    spi_serializer #(.WORD_WIDTH(9), .CLK_DIV(1), .CS_GAP(2)) dut_b (
        .clk(clk), .rst(rst), .s_valid(b_valid), .s_ready(b_ready),
        .s_data(b_data), .s_last(b_last), .lsb_first(b_lsb),
        .sclk(b_sclk), .sd(b_sd), .cs_n(b_cs_n), .busy(b_busy)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Serial-line observations, refreshed every negedge by tick().
    logic [15:0] a_vec;
    int          a_rises, a_cs_low, a_cs_runs;
    logic        a_prev_sclk = 1'b0, a_prev_cs_n = 1'b1;
    logic [15:0] b_vec;
    int          b_rises, b_cs_low, b_bad_period, b_last_rise;
    logic        b_prev_sclk = 1'b0;

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

    // Advance to the next negedge and record sclk rises and cs_n activity.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (a_sclk && !a_prev_sclk) begin
            a_vec = {a_vec[14:0], a_sd};
            a_rises++;
        end
        if (!a_cs_n) begin
            a_cs_low++;
            if (a_prev_cs_n) a_cs_runs++;
        end
        a_prev_sclk = a_sclk;
        a_prev_cs_n = a_cs_n;
        if (b_sclk && !b_prev_sclk) begin
            b_vec = {b_vec[14:0], b_sd};
            b_rises++;
            if (b_last_rise >= 0 && (cyc - b_last_rise) != 2) b_bad_period++;
            b_last_rise = cyc;
        end
        if (!b_cs_n) b_cs_low++;
        b_prev_sclk = b_sclk;
    endtask

    task automatic clear_obs();
        a_vec = '0; a_rises = 0; a_cs_low = 0; a_cs_runs = 0;
        a_prev_sclk = a_sclk; a_prev_cs_n = a_cs_n;
        b_vec = '0; b_rises = 0; b_cs_low = 0; b_bad_period = 0; b_last_rise = -1;
        b_prev_sclk = b_sclk;
    endtask

    // Offer a word on A and return one negedge after it is accepted.
    task automatic send_a(input logic [7:0] d, input logic last, input logic lsb);
        a_valid = 1'b1; a_data = d; a_last = last; a_lsb = lsb;
        for (int i = 0; i < 200; i++) begin
            if (a_ready) begin
                tick();
                return;
            end
            tick();
        end
        checks++; errors++;
        $display("FAIL send_timeout got ready=%b want 1", a_ready);
    endtask

    // Idle A's input and run until it returns to IDLE; hi_run = cs_n-high
    // cycles seen immediately before s_ready came back.
    task automatic drain_a(output int hi_run);
        a_valid = 1'b0;
        hi_run = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (a_ready && !a_busy) return;
            hi_run = a_cs_n ? hi_run + 1 : 0;
        end
        checks++; errors++;
        $display("FAIL drain_timeout got busy=%b want 0", a_busy);
    endtask

    task automatic test_reset();
        repeat (3) tick();
        checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b want 0", a_ready); end
        checks++; if (a_cs_n !== 1'b1) begin errors++; $display("FAIL rst_cs_n got %b want 1", a_cs_n); end
        checks++; if ({a_sclk, a_sd, a_busy} !== 3'b000) begin errors++; $display("FAIL rst_sclk_sd_busy got %b want 000", {a_sclk, a_sd, a_busy}); end
        checks++; if ({b_ready, b_cs_n, b_busy} !== 3'b010) begin errors++; $display("FAIL rst_b got %b want 010", {b_ready, b_cs_n, b_busy}); end
        rst = 1'b0;
        tick();
        checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready got %b want 1", a_ready); end
        checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL rst_release_busy got %b want 0", a_busy); end
    endtask

    task automatic test_single();
        int hi;
        clear_obs();
        send_a(8'h01, 1'b1, 1'b0);
        a_valid = 1'b0;
        checks++; if ({a_cs_n, a_sclk, a_sd, a_busy} !== 4'b0001) begin errors++; $display("FAIL single_start got %b want 0001", {a_cs_n, a_sclk, a_sd, a_busy}); end
        drain_a(hi);
        checks++; if (a_vec[7:0] !== 8'h01) begin errors++; $display("FAIL single_bits got %h want 01", a_vec[7:0]); end
        checks++; if (a_rises !== 8) begin errors++; $display("FAIL single_rises got %0d want 8", a_rises); end
        checks++; if (a_cs_low !== 32) begin errors++; $display("FAIL single_cs_low got %0d want 32", a_cs_low); end
        checks++; if (a_cs_runs !== 1) begin errors++; $display("FAIL single_cs_runs got %0d want 1", a_cs_runs); end
        checks++; if (hi < 2) begin errors++; $display("FAIL single_gap got %0d want >=2", hi); end
    endtask

    task automatic test_lsb_first();
        int hi;
        clear_obs();
        send_a(8'h01, 1'b1, 1'b1);
        a_valid = 1'b0;
        checks++; if (a_sd !== 1'b1) begin errors++; $display("FAIL lsb_first_bit got %b want 1", a_sd); end
        for (int i = 0; i < 30; i++) begin
            a_lsb = ~a_lsb;
            tick();
        end
        drain_a(hi);
        checks++; if (a_vec[7:0] !== 8'h80) begin errors++; $display("FAIL lsb_bits got %h want 80", a_vec[7:0]); end
        checks++; if (a_rises !== 8) begin errors++; $display("FAIL lsb_rises got %0d want 8", a_rises); end
    endtask

    task automatic test_back_to_back();
        int hi;
        clear_obs();
        send_a(8'h12, 1'b0, 1'b0);
        send_a(8'h34, 1'b1, 1'b0);
        drain_a(hi);
        checks++; if (a_vec !== 16'h1234) begin errors++; $display("FAIL b2b_bits got %h want 1234", a_vec); end
        checks++; if (a_rises !== 16) begin errors++; $display("FAIL b2b_rises got %0d want 16", a_rises); end
        checks++; if (a_cs_low !== 64) begin errors++; $display("FAIL b2b_cs_low got %0d want 64", a_cs_low); end
        checks++; if (a_cs_runs !== 1) begin errors++; $display("FAIL b2b_cs_runs got %0d want 1", a_cs_runs); end
    endtask

    task automatic test_hold();
        int hi;
        int hold_bad;
        clear_obs();
        send_a(8'hAA, 1'b0, 1'b0);
        a_valid = 1'b0;
        repeat (31) tick();
        hold_bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (a_sclk || a_cs_n || !a_ready || !a_busy) hold_bad++;
        end
        checks++; if (hold_bad !== 0) begin errors++; $display("FAIL hold_idle got %0d bad cycles want 0", hold_bad); end
        send_a(8'h55, 1'b1, 1'b0);
        drain_a(hi);
        checks++; if (a_vec !== 16'hAA55) begin errors++; $display("FAIL hold_bits got %h want aa55", a_vec); end
        checks++; if (a_rises !== 16) begin errors++; $display("FAIL hold_rises got %0d want 16", a_rises); end
        checks++; if (a_cs_runs !== 1) begin errors++; $display("FAIL hold_cs_runs got %0d want 1", a_cs_runs); end
        checks++; if (a_cs_low !== 74) begin errors++; $display("FAIL hold_cs_low got %0d want 74", a_cs_low); end
    endtask

    task automatic test_reset_mid();
        int guard;
        clear_obs();
        send_a(8'hF0, 1'b1, 1'b0);
        a_valid = 1'b0;
        guard = 0;
        while (a_rises < 3 && guard < 100) begin
            tick();
            guard++;
        end
        checks++; if (a_rises !== 3) begin errors++; $display("FAIL rmid_reach got %0d rises want 3", a_rises); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if ({a_cs_n, a_sclk} !== 2'b10) begin errors++; $display("FAIL rmid_abort got %b want 10", {a_cs_n, a_sclk}); end
        checks++; if ({a_ready, a_busy} !== 2'b00) begin errors++; $display("FAIL rmid_in_reset got %b want 00", {a_ready, a_busy}); end
        tick();
        checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready got %b want 1", a_ready); end
        repeat (40) tick();
        checks++; if (a_rises !== 3) begin errors++; $display("FAIL rmid_rises got %0d want 3", a_rises); end
        checks++; if (a_vec[2:0] !== 3'b111) begin errors++; $display("FAIL rmid_bits got %b want 111", a_vec[2:0]); end
        checks++; if (a_cs_low !== 11) begin errors++; $display("FAIL rmid_cs_low got %0d want 11", a_cs_low); end
    endtask

    task automatic test_width9();
        clear_obs();
        b_valid = 1'b1; b_data = 9'h1A5; b_last = 1'b1; b_lsb = 1'b0;
        checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL w9_ready got %b want 1", b_ready); end
        tick();
        b_valid = 1'b0;
        checks++; if ({b_cs_n, b_sclk, b_sd} !== 3'b001) begin errors++; $display("FAIL w9_start got %b want 001", {b_cs_n, b_sclk, b_sd}); end
        repeat (30) tick();
        checks++; if (b_vec[8:0] !== 9'h1A5) begin errors++; $display("FAIL w9_bits got %h want 1a5", b_vec[8:0]); end
        checks++; if (b_rises !== 9) begin errors++; $display("FAIL w9_rises got %0d want 9", b_rises); end
        checks++; if (b_bad_period !== 0) begin errors++; $display("FAIL w9_period got %0d bad want 0", b_bad_period); end
        checks++; if (b_cs_low !== 18) begin errors++; $display("FAIL w9_cs_low got %0d want 18", b_cs_low); end
        checks++; if ({b_ready, b_busy, b_cs_n} !== 3'b101) begin errors++; $display("FAIL w9_idle got %b want 101", {b_ready, b_busy, b_cs_n}); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_lsb_first();
        test_back_to_back();
        test_hold();
        test_reset_mid();
        test_width9();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
